rv_decode_stage: RTL and testbench

Registered, parametrised RISC-V decode stage sitting between the IF/ID instruction register and the register-file/execute stage of the CPU. Accepts a full 32-bit instruction word under a valid/ready handshake and decodes opcode/funct3. Produces registered control signals, register indices, a sign-extended XLEN immediate and per-byte store enables, with one cycle of latency, stall hold and flush. Supersedes the purely combinational opcode decoder.

---
 rtl/rv_decode_if.sv | 57 +++++
 rtl/rv_decode_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_rv_decode_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_if.sv
// Handshake and decoded-bundle signals between the IF/ID register, decode stage and execute.
// DECODE_ILLEGAL_TRAP_EN adds the illegal flag and illegal-word counter.
interface rv_decode_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        ImmType;
  logic [XLEN-1:0]   imm;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              RegWrite;
  logic              MemRead;
  logic              MemtoReg;
  logic              ALUSrc;
  logic              PCtoRegSrc;
  logic              RDSrc;
  logic [1:0]        ALUOP;
  logic [XLEN/8-1:0] MemWrite;
  logic [2:0]        ld_funct3;
  logic [2:0]        br_funct3;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic              is_lui;
  logic              is_auipc;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic              illegal;
  logic [CNT_W-1:0]  illegal_cnt;
`endif

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, ImmType, imm, rd, rs1, rs2, RegWrite, MemRead, MemtoReg,
           ALUSrc, PCtoRegSrc, RDSrc, ALUOP, MemWrite, ld_funct3, br_funct3, is_branch,
           is_jal, is_jalr, is_lui, is_auipc
`ifdef DECODE_ILLEGAL_TRAP_EN
           , illegal, illegal_cnt
`endif
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, ImmType, imm, rd, rs1, rs2, RegWrite, MemRead, MemtoReg,
           ALUSrc, PCtoRegSrc, RDSrc, ALUOP, MemWrite, ld_funct3, br_funct3, is_branch,
           is_jal, is_jalr, is_lui, is_auipc
`ifdef DECODE_ILLEGAL_TRAP_EN
           , illegal, illegal_cnt
`endif
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RISC-V decode stage: one-cycle latency, valid/ready stall hold and flush.
// DECODE_ILLEGAL_TRAP_EN exposes illegal and a saturating illegal-word counter.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  rv_decode_if.slave bus
);
  localparam int unsigned MaskW = XLEN / 8;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] ImmR = 3'b000;
  localparam logic [2:0] ImmI = 3'b001;
  localparam logic [2:0] ImmS = 3'b010;
  localparam logic [2:0] ImmB = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;
  localparam logic [2:0] ImmJ = 3'b101;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        load;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b  = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25],
                   bus.instr[11:8], 1'b0};
  assign imm_u  = {bus.instr[31:12], 12'b0};
  assign imm_j  = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12], bus.instr[20],
                   bus.instr[30:21], 1'b0};

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

  logic [2:0]       d_imm_type;
  logic [31:0]      d_imm32;
  logic             d_reg_write, d_mem_read, d_mem_to_reg, d_alu_src, d_pc_to_reg, d_rd_src;
  logic [1:0]       d_alu_op;
  logic [MaskW-1:0] d_mem_write;
  logic [2:0]       d_ld_funct3, d_br_funct3;
  logic             d_is_branch, d_is_jal, d_is_jalr, d_is_lui, d_is_auipc;
  logic             d_illegal;

  always_comb begin
    d_imm_type   = ImmR;
    d_imm32      = '0;
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_to_reg = 1'b0;
    d_alu_src    = 1'b0;
    d_pc_to_reg  = 1'b0;
    d_rd_src     = 1'b0;
    d_alu_op     = 2'b00;
    d_mem_write  = '0;
    d_ld_funct3  = 3'b000;
    d_br_funct3  = 3'b000;
    d_is_branch  = 1'b0;
    d_is_jal     = 1'b0;
    d_is_jalr    = 1'b0;
    d_is_lui     = 1'b0;
    d_is_auipc   = 1'b0;
    d_illegal    = 1'b0;
    case (opcode)
      OpR: begin
        d_reg_write = 1'b1;
        d_alu_src   = 1'b1;
      end
      OpLoad: begin
        d_imm_type   = ImmI;
        d_imm32      = imm_i;
        d_reg_write  = 1'b1;
        d_mem_read   = 1'b1;
        d_mem_to_reg = 1'b1;
        d_alu_op     = 2'b10;
        d_ld_funct3  = funct3;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: d_illegal = 1'b0;
          3'b011, 3'b110:                         d_illegal = (XLEN != 64);
          default:                                d_illegal = 1'b1;
        endcase
      end
      OpImm: begin
        d_imm_type  = ImmI;
        d_imm32     = imm_i;
        d_reg_write = 1'b1;
        d_alu_op    = 2'b01;
      end
      OpJalr: begin
        d_imm_type  = ImmI;
        d_imm32     = imm_i;
        d_reg_write = 1'b1;
        d_pc_to_reg = 1'b1;
        d_rd_src    = 1'b1;
        d_alu_op    = 2'b10;
        d_is_jalr   = 1'b1;
      end
      OpStore: begin
        d_imm_type = ImmS;
        d_imm32    = imm_s;
        d_alu_op   = 2'b10;
        case (funct3)
          3'b000: d_mem_write = MaskW'(8'h01);
          3'b001: d_mem_write = MaskW'(8'h03);
          3'b010: d_mem_write = MaskW'(8'h0F);
          3'b011: begin
            if (XLEN == 64) d_mem_write = '1;
            else            d_illegal   = 1'b1;
          end
          default: d_illegal = 1'b1;
        endcase
      end
      OpBranch: begin
        d_imm_type  = ImmB;
        d_imm32     = imm_b;
        d_alu_op    = 2'b11;
        d_br_funct3 = funct3;
        d_is_branch = 1'b1;
      end
      OpLui, OpAuipc: begin
        d_imm_type  = ImmU;
        d_imm32     = imm_u;
        d_reg_write = 1'b1;
        d_pc_to_reg = 1'b1;
        d_rd_src    = 1'b1;
        d_is_lui    = (opcode == OpLui);
        d_is_auipc  = (opcode == OpAuipc);
      end
      OpJal: begin
        d_imm_type  = ImmJ;
        d_imm32     = imm_j;
        d_reg_write = 1'b1;
        d_pc_to_reg = 1'b1;
        d_rd_src    = 1'b1;
        d_is_jal    = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (bus.instr[1:0] != 2'b11) d_illegal = 1'b1;
    // An illegal word travels as a NOP: nothing downstream may write or branch.
    if (d_illegal) begin
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = '0;
      d_is_branch = 1'b0;
      d_is_jal    = 1'b0;
      d_is_jalr   = 1'b0;
      d_is_lui    = 1'b0;
      d_is_auipc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.ImmType    <= '0;
      bus.imm        <= '0;
      bus.rd         <= '0;
      bus.rs1        <= '0;
      bus.rs2        <= '0;
      bus.RegWrite   <= 1'b0;
      bus.MemRead    <= 1'b0;
      bus.MemtoReg   <= 1'b0;
      bus.ALUSrc     <= 1'b0;
      bus.PCtoRegSrc <= 1'b0;
      bus.RDSrc      <= 1'b0;
      bus.ALUOP      <= '0;
      bus.MemWrite   <= '0;
      bus.ld_funct3  <= '0;
      bus.br_funct3  <= '0;
      bus.is_branch  <= 1'b0;
      bus.is_jal     <= 1'b0;
      bus.is_jalr    <= 1'b0;
      bus.is_lui     <= 1'b0;
      bus.is_auipc   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.illegal     <= 1'b0;
      bus.illegal_cnt <= '0;
`endif
    end else if (load) begin
      bus.out_valid  <= 1'b1;
      bus.ImmType    <= d_imm_type;
      bus.imm        <= XLEN'($signed(d_imm32));
      bus.rd         <= bus.instr[11:7];
      bus.rs1        <= bus.instr[19:15];
      bus.rs2        <= bus.instr[24:20];
      bus.RegWrite   <= d_reg_write;
      bus.MemRead    <= d_mem_read;
      bus.MemtoReg   <= d_mem_to_reg;
      bus.ALUSrc     <= d_alu_src;
      bus.PCtoRegSrc <= d_pc_to_reg;
      bus.RDSrc      <= d_rd_src;
      bus.ALUOP      <= d_alu_op;
      bus.MemWrite   <= d_mem_write;
      bus.ld_funct3  <= d_ld_funct3;
      bus.br_funct3  <= d_br_funct3;
      bus.is_branch  <= d_is_branch;
      bus.is_jal     <= d_is_jal;
      bus.is_jalr    <= d_is_jalr;
      bus.is_lui     <= d_is_lui;
      bus.is_auipc   <= d_is_auipc;
`ifdef DECODE_ILLEGAL_TRAP_EN
      bus.illegal <= d_illegal;
      if (d_illegal && (bus.illegal_cnt != {CNT_W{1'b1}})) begin
        bus.illegal_cnt <= bus.illegal_cnt + CNT_W'(1);
      end
`endif
    end else if (bus.flush || bus.out_ready) begin
      // Flush or consume without refill: drop to a bubble with every enable cleared.
      bus.out_valid <= 1'b0;
      bus.RegWrite  <= 1'b0;
      bus.MemRead   <= 1'b0;
      bus.MemWrite  <= '0;
      bus.is_branch <= 1'b0;
      bus.is_jal    <= 1'b0;
      bus.is_jalr   <= 1'b0;
      bus.is_lui    <= 1'b0;
      bus.is_auipc  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed words, expected bundles queued at issue.
// Build with DECODE_ILLEGAL_TRAP_EN to also check illegal and illegal_cnt.
module tb_rv_decode_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned MW    = XLEN / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_decode_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]      instr;
    logic             chk_data;
    logic [2:0]       imm_type;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rd, rs1, rs2;
    logic             reg_write, mem_read, mem_to_reg, alu_src, pc_to_reg, rd_src;
    logic [1:0]       alu_op;
    logic [MW-1:0]    mem_write;
    logic [2:0]       ld_f3, br_f3;
    logic             is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             q[$];
  int               n_vec   = 0;
  int               n_miss  = 0;
  bit               mon_en  = 1'b0;
  logic [CNT_W-1:0] cur_cnt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2);
    exp_t e;
    e           = '{default: '0};
    e.instr     = w;
    e.chk_data  = 1'b1;
    e.rd        = rd;
    e.rs1       = rs1;
    e.rs2       = rs2;
    e.cnt       = cur_cnt;
    return e;
  endfunction

  task automatic cmp(input exp_t e);
    string t;
    t = $sformatf("%08h", e.instr);
    check({"RegWrite/", t}, bus.RegWrite, e.reg_write);
    check({"MemRead/", t}, bus.MemRead, e.mem_read);
    check({"MemWrite/", t}, bus.MemWrite, e.mem_write);
    check({"flags/", t}, {bus.is_branch, bus.is_jal, bus.is_jalr, bus.is_lui, bus.is_auipc},
          {e.is_branch, e.is_jal, e.is_jalr, e.is_lui, e.is_auipc});
    if (e.chk_data) begin
      check({"ImmType/", t}, bus.ImmType, e.imm_type);
      check({"imm/", t}, bus.imm, e.imm);
      check({"regs/", t}, {bus.rd, bus.rs1, bus.rs2}, {e.rd, e.rs1, e.rs2});
      check({"ctl/", t}, {bus.MemtoReg, bus.ALUSrc, bus.PCtoRegSrc, bus.RDSrc},
            {e.mem_to_reg, e.alu_src, e.pc_to_reg, e.rd_src});
      check({"ALUOP/", t}, bus.ALUOP, e.alu_op);
      if (e.mem_read) check({"ld_funct3/", t}, bus.ld_funct3, e.ld_f3);
      if (e.is_branch) check({"br_funct3/", t}, bus.br_funct3, e.br_f3);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    check({"illegal/", t}, bus.illegal, e.ill);
    check({"illegal_cnt/", t}, bus.illegal_cnt, e.cnt);
`endif
  endtask

  // Monitor: pop one expectation per consumed bundle; bubbles must carry no enables.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("unexpected_bundle", 64'(bus.out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            cmp(e);
          end
        end else if (!bus.out_valid) begin
          check("bubble_enables", {bus.RegWrite, bus.MemRead, bus.MemWrite}, 64'd0);
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  task automatic send(input exp_t e);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr    = e.instr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'd0, 64'd1);
    else q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  exp_t             e, e_lw, e_addi;
  logic [CNT_W-1:0] cnt_tab[5];

  initial begin
    cnt_tab       = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_imm", bus.imm, '0);
    check("rst_ctl", {bus.RegWrite, bus.MemRead, bus.MemtoReg, bus.ALUSrc, bus.PCtoRegSrc,
                      bus.RDSrc, bus.ALUOP, bus.MemWrite}, 64'd0);
    check("rst_flags", {bus.is_branch, bus.is_jal, bus.is_jalr, bus.is_lui, bus.is_auipc},
          64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("rst_illegal", {bus.illegal, bus.illegal_cnt}, 64'd0);
`endif
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // add x3,x1,x2
    e = mk(32'h002081B3, 5'd3, 5'd1, 5'd2);
    e.reg_write = 1'b1; e.alu_src = 1'b1;
    send(e);
    @(negedge clk);
    check("add_latency", bus.out_valid, 1'b1);
    @(posedge clk);
    #1;

    // sb, sh, sw back to back
    e = mk(32'h00208023, 5'd0, 5'd1, 5'd2);
    e.imm_type = 3'b010; e.alu_op = 2'b10; e.mem_write = 4'h1;
    send(e);
    e.instr = 32'h00209023; e.mem_write = 4'h3;
    send(e);
    e.instr = 32'h0020A023; e.mem_write = 4'hF;
    send(e);

    // lui x5,0xFFFFF
    e = mk(32'hFFFFF2B7, 5'd5, 5'd31, 5'd31);
    e.imm_type = 3'b100; e.imm = 32'hFFFFF000; e.reg_write = 1'b1;
    e.pc_to_reg = 1'b1; e.rd_src = 1'b1; e.is_lui = 1'b1;
    send(e);
    // jal x0,-12
    e = mk(32'hFF5FF06F, 5'd0, 5'd31, 5'd21);
    e.imm_type = 3'b101; e.imm = 32'hFFFFFFF4; e.reg_write = 1'b1;
    e.pc_to_reg = 1'b1; e.rd_src = 1'b1; e.is_jal = 1'b1;
    send(e);
    // beq x1,x2,+8
    e = mk(32'h00208463, 5'd8, 5'd1, 5'd2);
    e.imm_type = 3'b011; e.imm = 32'd8; e.alu_op = 2'b11; e.is_branch = 1'b1;
    e.br_f3 = 3'b000;
    send(e);
    // jalr x1,0(x5)
    e = mk(32'h000280E7, 5'd1, 5'd5, 5'd0);
    e.imm_type = 3'b001; e.reg_write = 1'b1; e.pc_to_reg = 1'b1; e.rd_src = 1'b1;
    e.alu_op = 2'b10; e.is_jalr = 1'b1;
    send(e);
    @(posedge clk);
    #1;

    // lw x6,8(x1) held for 3 cycles; addi x7,x0,-1 waits and then replaces it
    e_lw = mk(32'h0080A303, 5'd6, 5'd1, 5'd8);
    e_lw.imm_type = 3'b001; e_lw.imm = 32'd8; e_lw.reg_write = 1'b1; e_lw.mem_read = 1'b1;
    e_lw.mem_to_reg = 1'b1; e_lw.alu_op = 2'b10; e_lw.ld_f3 = 3'b010;
    e_addi = mk(32'hFFF00393, 5'd7, 5'd0, 5'd31);
    e_addi.imm_type = 3'b001; e_addi.imm = 32'hFFFFFFFF; e_addi.reg_write = 1'b1;
    e_addi.alu_op = 2'b01;
    bus.out_ready = 1'b0;
    send(e_lw);
    bus.in_valid = 1'b1;
    bus.instr    = e_addi.instr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 1'b0);
      check("stall_out_valid", bus.out_valid, 1'b1);
      cmp(e_lw);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    q.push_back(e_addi);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Flush with a held sb and an incoming add: neither may appear
    bus.out_ready = 1'b0;
    e = mk(32'h00208023, 5'd0, 5'd1, 5'd2);
    e.imm_type = 3'b010; e.alu_op = 2'b10; e.mem_write = 4'h1;
    send(e);
    void'(q.pop_back());
    bus.in_valid = 1'b1;
    bus.instr    = 32'h002081B3;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_enables", {bus.RegWrite, bus.MemWrite}, 64'd0);
    @(posedge clk);
    #1;

    // auipc x10,1
    e = mk(32'h00001517, 5'd10, 5'd0, 5'd0);
    e.imm_type = 3'b100; e.imm = 32'h00001000; e.reg_write = 1'b1;
    e.pc_to_reg = 1'b1; e.rd_src = 1'b1; e.is_auipc = 1'b1;
    send(e);

    // Five all-zero words: illegal, counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      cur_cnt = cnt_tab[i];
      e = mk(32'h00000000, 5'd0, 5'd0, 5'd0);
      e.chk_data = 1'b0; e.ill = 1'b1;
      send(e);
    end
    // sd on XLEN=32 and load funct3 110: both illegal
    e = mk(32'h0020B023, 5'd0, 5'd1, 5'd2);
    e.chk_data = 1'b0; e.ill = 1'b1;
    send(e);
    e = mk(32'h0080E303, 5'd6, 5'd1, 5'd8);
    e.chk_data = 1'b0; e.ill = 1'b1;
    send(e);
    // Legal word afterwards clears illegal, count stays
    send(e_addi);
    e_addi.cnt = cur_cnt;
    q[q.size()-1] = e_addi;

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
